l1_refill: RTL
==============

# l1_refill

Miss-refill engine sitting directly downstream of the L1 read cache's miss path and upstream of main memory. On an L1 miss it accepts the missing address, fetches the enclosing 4-word (128-bit) block from main memory one 32-bit word at a time over a request/valid handshake, and assembles the words. It then presents the block to L1 with a one-cycle `delivered` pulse, which L1 uses to fill the LRU way.

## Interface
- `ADDR_W`, 32, byte-address width.
- `WORD_W`, 32, memory data word width.
- `WORDS`, 4, words per block; block width is `WORDS*WORD_W` = 128.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `miss_req`  in  1  L1 requests a refill.
- `miss_addr`  in  ADDR_W  byte address of the missing word; sampled on acceptance.
- `miss_ack`  out  1  refill accepted this cycle; equals `miss_req` while IDLE.
- `busy`  out  1  high in every state except IDLE.
- `delivered`  out  1  one-cycle pulse; `blockout` is valid.
- `blockout`  out  128  assembled block; connects to L1 `blockin`.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  word-aligned read address.
- `mem_ready`  in  1  memory accepts `mem_req` this cycle.
- `mem_rvalid`  in  1  `mem_rdata` valid this cycle.
- `mem_rdata`  in  WORD_W  returned word.

## Operation
- Reset (`rst`=0, asynchronous):
  - State → IDLE; word index → 0.
  - `blockout`, captured base address, `mem_addr` → 0.
  - `mem_req`, `delivered`, `busy` → 0.
  - Reset mid-refill abandons the refill; nothing is delivered.
- State machine:
  - **IDLE**: `miss_ack` = `miss_req`. On accept, latch `base = {miss_addr[ADDR_W-1:4], 4'b0}`, set index to 0, and go to ISSUE.
  - **ISSUE**: `mem_req`=1, `mem_addr = base + 4*index`. Hold both stable until `mem_ready`=1, then go to WAIT.
  - **WAIT**: `mem_req`=0. On `mem_rvalid`, write `mem_rdata` into `blockout[32*index +: 32]`. If index==3, go to DELIVER; otherwise increment index and go to ISSUE.
  - **DELIVER**: `delivered`=1 for exactly this cycle, then go to IDLE.
- Exactly one outstanding memory read at a time. Words are fetched in ascending order 0..3; there is no critical-word-first.
- `mem_rvalid` is ignored in every state except WAIT, including stale responses after reset.
- `miss_req` outside IDLE is not acknowledged. L1 holds the request until `miss_ack`.
- `blockout` holds its contents after DELIVER until the next word write of a new refill.
- Address arithmetic: the index is 2 bits. `base + 4*index` never carries out of bits [3:0]; only concatenation is needed, no adder.
- `miss_addr[3:0]` is ignored beyond selecting the block.

## Timing
- `miss_ack` is combinational from `miss_req` and the state. Every other output is registered.
- Best case (`mem_ready` high in ISSUE, `mem_rvalid` high the first WAIT cycle):
  - Acceptance at edge E0 → ISSUE after E0, WAIT after E1, ISSUE after E2, and so on.
  - DELIVER is entered after E8, so `delivered` is high in the 9th cycle after acceptance.
- Each stall cycle of `mem_ready` or `mem_rvalid` adds exactly one cycle.
- The earliest new acceptance is the cycle after DELIVER, when the state is IDLE again.
- A `miss_req` asserted during the DELIVER cycle is acknowledged in the following cycle.

## Structure
- Shared package `l1_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} refill_state_t`;
  - `localparam BLOCK_W = 128`, `WORD_W = 32`, `OFFSET_BITS = 4`;
  - a `block_base()` function that clears the offset bits.
- The L1 cache imports the same package for the block width.
- No sub-module: one FSM, a 2-bit index counter and a 128-bit assembly register, all in this module.

## Test plan
- Reset, then `miss_req`=1, `miss_addr`=0x0000_1238; memory always ready, returns 0xA0, 0xA1, 0xA2, 0xA3 one cycle after each request:
  - `mem_addr` sequence is 0x1230, 0x1234, 0x1238, 0x123C;
  - `delivered` pulses 9 cycles after accept;
  - `blockout` = 0x000000A3_000000A2_000000A1_000000A0.
- Backpressure: `mem_ready` low for 3 cycles on word 1 → `mem_req` and `mem_addr` (0x1234) stay stable throughout, and `delivered` arrives 3 cycles later than in the first test.
- Spurious `mem_rvalid` (data 0xDEAD) pulsed while in IDLE and while in ISSUE → `blockout` unchanged, no state change.
- `miss_req` held high continuously across two refills (0x100, then 0x200 at DELIVER) → `miss_ack` low during the busy cycles, second acceptance the cycle after `delivered`, second fetch starts at 0x200.
- `rst` driven low in WAIT of word 2 while `mem_rvalid` arrives the same cycle → outputs return to reset values immediately, no `delivered`, and `mem_req` stays 0 until a new `miss_req`.

Source files
------------

// File: rtl/l1_pkg.sv
// Shared L1 definitions: refill FSM encoding, block geometry and address helpers.
package l1_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} refill_state_t;

  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned OFFSET_BITS = 4;

  // Clears the byte offset within a block, giving the block's base address.
  function automatic logic [31:0] block_base(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_refill.sv
// L1 miss-refill engine: fetches a 4-word block one word at a time and presents it
// to the cache with a single-cycle delivered pulse.
module l1_refill #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      miss_req_i,
  input  logic [ADDR_W-1:0]         miss_addr_i,
  output logic                      miss_ack_o,
  output logic                      busy_o,
  output logic                      delivered_o,
  output logic [WORDS*WORD_W-1:0]   blockout_o,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_rvalid_i,
  input  logic [WORD_W-1:0]         mem_rdata_i
);
  import l1_pkg::*;

  localparam int unsigned IdxW = $clog2(WORDS);

  refill_state_t             state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [WORDS*WORD_W-1:0]   blk_q, blk_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic                      mem_req_q, mem_req_d;
  logic                      busy_q, busy_d;
  logic                      delivered_q, delivered_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    blk_d      = blk_q;
    miss_ack_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ack_o = miss_req_i;
        if (miss_req_i) begin
          base_d  = block_base(miss_addr_i);
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready_i) state_d = WAIT;
      end
      WAIT: begin
        // Responses are only honoured here, so stale returns after reset are dropped.
        if (mem_rvalid_i) begin
          blk_d[WORD_W*idx_q +: WORD_W] = mem_rdata_i;
          if (idx_q == IdxW'(WORDS - 1)) begin
            state_d = DELIVER;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    mem_req_d   = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
    delivered_d = (state_d == DELIVER);
    mem_addr_d  = (state_d == ISSUE) ? {base_d[ADDR_W-1:OFFSET_BITS], idx_d, 2'b00}
                                     : mem_addr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      blk_q       <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      delivered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      blk_q       <= blk_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      delivered_q <= delivered_d;
    end
  end

  assign busy_o      = busy_q;
  assign delivered_o = delivered_q;
  assign blockout_o  = blk_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;

endmodule
